// File: rtl/result_display_if.sv
// Signal bundle between the processor core and the result display stage:
// result word, phase and render mode in; segment/digit drive, phase LEDs and busy out.
interface result_display_if;
    logic [15:0] value;
    logic [4:0]  phase;
    logic        hexMode;
    logic [6:0]  seg;
    logic [5:0]  digitSel;
    logic [4:0]  phaseLed;
    logic        busy;

    modport master (
        output value, phase, hexMode,
        input  seg, digitSel, phaseLed, busy
    );

    modport slave (
        input  value, phase, hexMode,
        output seg, digitSel, phaseLed, busy
    );
endinterface

// File: rtl/result_display.sv
// Six-digit multiplexed seven-segment result display with a sequential
// double-dabble converter (signed decimal or hex) and atomic digit commit.
module result_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic             clock,
    input  logic             nReset,
    result_display_if.slave  bus
);

    localparam int         CW         = $clog2(REFRESH_DIV);
    localparam logic [4:0] CODE_DASH  = 5'd16;
    localparam logic [4:0] CODE_BLANK = 5'd17;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

    state_t           state_reg;
    logic             valid_reg;
    logic             last_mode_reg;
    logic [15:0]      last_value_reg;
    logic             neg_reg;
    logic             busy_reg;
    logic [15:0]      mag_reg;
    logic [19:0]      bcd_reg;
    logic [3:0]       shift_cnt_reg;
    logic [5:0][4:0]  code_reg;

    logic [19:0]      bcd_adj;
    logic [2:0]       msd;
    logic [5:0][4:0]  commit_code;

    logic [CW-1:0]    refresh_cnt_reg;
    logic [2:0]       digit_idx_reg;
    logic [5:0]       digit_sel_reg;
    logic [6:0]       seg_reg;
    logic [4:0]       phase_led_reg;

    logic             wrap;
    logic [2:0]       digit_idx_next;
    logic [4:0]       shown_code;

    function automatic logic [6:0] glyph(input logic [4:0] code);
        case (code)
            5'd0:    glyph = 7'b1000000;
            5'd1:    glyph = 7'b1111001;
            5'd2:    glyph = 7'b0100100;
            5'd3:    glyph = 7'b0110000;
            5'd4:    glyph = 7'b0011001;
            5'd5:    glyph = 7'b0010010;
            5'd6:    glyph = 7'b0000010;
            5'd7:    glyph = 7'b1111000;
            5'd8:    glyph = 7'b0000000;
            5'd9:    glyph = 7'b0010000;
            5'd10:   glyph = 7'b0001000;
            5'd11:   glyph = 7'b0000011;
            5'd12:   glyph = 7'b1000110;
            5'd13:   glyph = 7'b0100001;
            5'd14:   glyph = 7'b0000110;
            5'd15:   glyph = 7'b0001110;
            5'd16:   glyph = 7'b0111111;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
    for (genvar gi = 0; gi < 5; gi++) begin : g_add3
        assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                    bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end

    // Position of the most significant non-zero BCD digit (0 when the value is 0).
    always_comb begin
        msd = 3'd0;
        for (int i = 1; i < 5; i++) begin
            if (bcd_reg[i*4 +: 4] != 4'd0) msd = 3'(i);
        end
    end

    for (genvar gi = 0; gi < 6; gi++) begin : g_code
        logic [4:0] hex_code;
        logic [4:0] dec_code;
        if (gi < 4) begin : g_hex
            assign hex_code = {1'b0, last_value_reg[gi*4 +: 4]};
        end else begin : g_hex_blank
            assign hex_code = CODE_BLANK;
        end
        if (gi == 0) begin : g_dec_lsd
            assign dec_code = {1'b0, bcd_reg[3:0]};
        end else if (gi < 5) begin : g_dec_mid
            assign dec_code = (3'(gi) <= msd)                 ? {1'b0, bcd_reg[gi*4 +: 4]} :
                              (neg_reg && (3'(gi - 1) == msd)) ? CODE_DASH : CODE_BLANK;
        end else begin : g_dec_top
            assign dec_code = (neg_reg && (msd == 3'd4)) ? CODE_DASH : CODE_BLANK;
        end
        assign commit_code[gi] = last_mode_reg ? hex_code : dec_code;
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_reg      <= IDLE;
            valid_reg      <= 1'b0;
            last_mode_reg  <= 1'b0;
            last_value_reg <= 16'd0;
            neg_reg        <= 1'b0;
            busy_reg       <= 1'b0;
            mag_reg        <= 16'd0;
            bcd_reg        <= 20'd0;
            shift_cnt_reg  <= 4'd0;
            code_reg       <= {6{CODE_BLANK}};
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!valid_reg || ({bus.hexMode, bus.value} != {last_mode_reg, last_value_reg}))
                        state_reg <= LOAD;
                end
                LOAD: begin
                    last_value_reg <= bus.value;
                    last_mode_reg  <= bus.hexMode;
                    valid_reg      <= 1'b1;
                    neg_reg        <= bus.value[15];
                    mag_reg        <= bus.value[15] ? (~bus.value + 16'd1) : bus.value;
                    bcd_reg        <= 20'd0;
                    shift_cnt_reg  <= 4'd0;
                    busy_reg       <= 1'b1;
                    state_reg      <= bus.hexMode ? COMMIT : SHIFT;
                end
                SHIFT: begin
                    {bcd_reg, mag_reg} <= {bcd_adj[18:0], mag_reg, 1'b0};
                    shift_cnt_reg      <= shift_cnt_reg + 4'd1;
                    if (shift_cnt_reg == 4'd15) state_reg <= COMMIT;
                end
                COMMIT: begin
                    code_reg  <= commit_code;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // seg follows the code that will be current after this edge, so a commit
    // lands on the selected digit in the same cycle as the code registers.
    always_comb begin
        wrap           = (refresh_cnt_reg == CW'(REFRESH_DIV - 1));
        digit_idx_next = digit_idx_reg;
        if (wrap) digit_idx_next = (digit_idx_reg == 3'd5) ? 3'd0 : digit_idx_reg + 3'd1;
        shown_code = (state_reg == COMMIT) ? commit_code[digit_idx_next] : code_reg[digit_idx_next];
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            refresh_cnt_reg <= '0;
            digit_idx_reg   <= 3'd0;
            digit_sel_reg   <= 6'b111110;
            seg_reg         <= 7'b1111111;
            phase_led_reg   <= 5'd0;
        end else begin
            refresh_cnt_reg <= wrap ? '0 : refresh_cnt_reg + 1'b1;
            digit_idx_reg   <= digit_idx_next;
            digit_sel_reg   <= ~(6'b000001 << digit_idx_next);
            seg_reg         <= glyph(shown_code);
            phase_led_reg   <= bus.phase;
        end
    end

    assign bus.seg      = seg_reg;
    assign bus.digitSel = digit_sel_reg;
    assign bus.phaseLed = phase_led_reg;
    assign bus.busy     = busy_reg;

endmodule

// File: tb/tb_result_display.sv
// Directed bench for result_display: vector table of values/modes with expected
// glyph frames, plus hand sequences for reset, mid-conversion change and stepping.
module tb_result_display;

    localparam int DIV = 4;

    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G6 = 7'b0000010, G7 = 7'b1111000;
    localparam logic [6:0] G8 = 7'b0000000, G9 = 7'b0010000, GA = 7'b0001000, GB = 7'b0000011;
    localparam logic [6:0] GC = 7'b1000110, GD = 7'b0100001, GE = 7'b0000110, GF = 7'b0001110;
    localparam logic [6:0] DS = 7'b0111111, BL = 7'b1111111;

    typedef struct {
        logic [15:0]     value;
        logic            hex;
        int              fall;
        logic [5:0][6:0] exp;   // digit 5 .. digit 0
    } vec_t;

    logic clock = 1'b0;
    logic nReset = 1'b0;
    result_display_if bus();

    result_display #(.REFRESH_DIV(DIV)) dut (
        .clock  (clock),
        .nReset (nReset),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    logic [5:0][6:0] got;
    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int sel_idx(input logic [5:0] s);
        int r = -1;
        for (int i = 0; i < 6; i++) if (s == ~(6'b000001 << i)) r = i;
        return r;
    endfunction

    // Runs until busy has risen and fallen; fall is the edge index relative to
    // the first edge after the stimulus (edge 0), or -1 on timeout.
    task automatic measure(output int fall, output int busy_cnt);
        logic seen = 1'b0;
        fall = -1;
        busy_cnt = 0;
        for (int t = 0; t < 60 && fall < 0; t++) begin
            tick();
            if (bus.busy) begin
                busy_cnt++;
                seen = 1'b1;
            end else if (seen) begin
                fall = t;
            end
        end
    endtask

    task automatic capture_frame();
        int k;
        got = {6{7'h55}};
        for (int t = 0; t < 6 * DIV; t++) begin
            tick();
            k = sel_idx(bus.digitSel);
            if (k >= 0) got[k] = bus.seg;
        end
    endtask

    initial begin
        int fall, bc, k;
        int fall1, rise2, fall2;
        logic prev_busy;
        logic [5:0][6:0] old_fr;
        logic [6:0] exp_seg;

        vecs[0]  = '{16'h8000, 1'b0, 18, {DS, G3, G2, G7, G6, G8}};
        vecs[1]  = '{16'hFFFF, 1'b0, 18, {BL, BL, BL, BL, DS, G1}};
        vecs[2]  = '{16'd12345, 1'b0, 18, {BL, G1, G2, G3, G4, G5}};
        vecs[3]  = '{16'hBEEF, 1'b1, 2,  {BL, BL, GB, GE, GE, GF}};
        vecs[4]  = '{16'hBEEF, 1'b0, 18, {DS, G1, G6, G6, G5, G7}};
        vecs[5]  = '{16'h7FFF, 1'b0, 18, {BL, G3, G2, G7, G6, G7}};
        vecs[6]  = '{16'h0000, 1'b1, 2,  {BL, BL, G0, G0, G0, G0}};
        vecs[7]  = '{16'd100, 1'b0, 18,  {BL, BL, BL, G1, G0, G0}};
        vecs[8]  = '{16'hFF9C, 1'b0, 18, {BL, BL, DS, G1, G0, G0}};
        vecs[9]  = '{16'hA5C3, 1'b1, 2,  {BL, BL, GA, G5, GC, G3}};
        vecs[10] = '{16'd9, 1'b0, 18,    {BL, BL, BL, BL, BL, G9}};
        vecs[11] = '{16'h0D20, 1'b1, 2,  {BL, BL, G0, GD, G2, G0}};

        // Reset state, then the post-reset conversion of 0.
        bus.value = 16'd0;
        bus.hexMode = 1'b0;
        bus.phase = 5'd0;
        tick();
        tick();
        check("reset_seg", 64'(bus.seg), 64'(BL));
        check("reset_digitsel", 64'(bus.digitSel), 64'(6'b111110));
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_phaseled", 64'(bus.phaseLed), 64'd0);
        nReset = 1'b1;
        measure(fall, bc);
        check("zero_fall_edge", 64'(fall), 64'd18);
        check("zero_busy_cycles", 64'(bc), 64'd17);
        capture_frame();
        check("zero_frame", 64'(got), 64'({BL, BL, BL, BL, BL, G0}));

        // Table-driven conversions.
        for (int i = 0; i < 12; i++) begin
            bus.value = vecs[i].value;
            bus.hexMode = vecs[i].hex;
            measure(fall, bc);
            check($sformatf("vec%0d_fall_edge", i), 64'(fall), 64'(vecs[i].fall));
            if (!vecs[i].hex) check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'd17);
            capture_frame();
            check($sformatf("vec%0d_frame", i), 64'(got), 64'(vecs[i].exp));
        end

        // Value changes three cycles into a conversion.
        old_fr = {BL, BL, G1, G0, G0, G0};
        bus.value = 16'd1000;
        bus.hexMode = 1'b0;
        fall1 = -1;
        rise2 = -1;
        fall2 = -1;
        prev_busy = 1'b0;
        for (int t = 0; t < 80 && fall2 < 0; t++) begin
            tick();
            if (t == 3) bus.value = 16'hFFFB;
            if (prev_busy && !bus.busy) begin
                if (fall1 < 0) begin
                    fall1 = t;
                    k = sel_idx(bus.digitSel);
                    exp_seg = (k >= 0) ? old_fr[k] : 7'h55;
                    check("midchg_first_commit_seg", 64'(bus.seg), 64'(exp_seg));
                end else begin
                    fall2 = t;
                end
            end
            if (!prev_busy && bus.busy && fall1 >= 0) rise2 = t;
            prev_busy = bus.busy;
        end
        check("midchg_first_fall", 64'(fall1), 64'd18);
        check("midchg_second_rise", 64'(rise2), 64'd20);
        check("midchg_second_fall", 64'(fall2), 64'd37);
        capture_frame();
        check("midchg_final_frame", 64'(got), 64'({BL, BL, BL, BL, DS, G5}));

        // Reset asserted during SHIFT, then scan stepping and phase delay after release.
        bus.value = 16'h0042;
        for (int t = 0; t < 5; t++) tick();
        check("pre_reset_busy", 64'(bus.busy), 64'd1);
        nReset = 1'b0;
        #1;
        check("async_reset_seg", 64'(bus.seg), 64'(BL));
        check("async_reset_digitsel", 64'(bus.digitSel), 64'(6'b111110));
        check("async_reset_busy", 64'(bus.busy), 64'd0);
        tick();
        nReset = 1'b1;
        bus.phase = 5'b00100;
        #1;
        check("phaseled_before_edge", 64'(bus.phaseLed), 64'd0);
        fall = -1;
        prev_busy = 1'b0;
        for (int t = 0; t < 60 && fall < 0; t++) begin
            tick();
            if (t == 0) check("phaseled_after_edge", 64'(bus.phaseLed), 64'(5'b00100));
            if (t == 2) check("digitsel_dwell", 64'(bus.digitSel), 64'(6'b111110));
            if (t == 3) check("digitsel_step", 64'(bus.digitSel), 64'(6'b111101));
            if (prev_busy && !bus.busy) fall = t;
            prev_busy = bus.busy;
        end
        check("post_reset_fall", 64'(fall), 64'd18);
        capture_frame();
        check("post_reset_frame", 64'(got), 64'({BL, BL, BL, BL, G6, G6}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
